// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution stage.
//   - operator codes (OP_ADD..OP_DIV), signed data-type code
//   - FSM state enum
//   - bit positions inside the 2-bit err vector
package alu_pkg;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4;
    localparam logic [4:0] OP_MUL = 5'd5;
    localparam logic [4:0] OP_DIV = 5'd6;

    // Only this data_type value selects signed arithmetic.
    localparam logic [3:0] DT_SIGNED = 4'd1;

    localparam int unsigned ERR_DIV0    = 0;
    localparam int unsigned ERR_ILLEGAL = 1;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StDone
    } state_e;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned (magnitude) multiply / restoring divide engine.
// One iteration per clock, DATA_W iterations per operation.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   start_i       load operands and begin (takes priority over a running op)
//   is_div_i      1 = divide, 0 = multiply (sampled with start_i)
//   a_i, b_i      multiplicand/multiplier or dividend/divisor magnitudes
//   done_o        high once the last iteration has completed, until next start
//   res_o         product, or {remainder, quotient}
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  is_div_i,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    output logic                  done_o,
    output logic [2*DATA_W-1:0]   res_o
);

    logic              run_q, run_d;
    logic              done_q, done_d;
    logic              div_q, div_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // hi: product high half / partial remainder; lo: multiplier / quotient
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] b_q, b_d;

    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W:0]   div_diff;

    always_comb begin
        run_d  = run_q;
        done_d = done_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        b_d    = b_q;

        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q, lo_q[DATA_W-1]};
        // Top bit set means the trial subtraction went negative (restore).
        div_diff  = div_shift - {1'b0, b_q};

        if (start_i) begin
            run_d  = 1'b1;
            done_d = 1'b0;
            div_d  = is_div_i;
            cnt_d  = '0;
            hi_d   = '0;
            lo_d   = a_i;
            b_d    = b_i;
        end else if (run_q) begin
            if (div_q) begin
                if (!div_diff[DATA_W]) begin
                    hi_d = div_diff[DATA_W-1:0];
                    lo_d = {lo_q[DATA_W-2:0], 1'b1};
                end else begin
                    hi_d = div_shift[DATA_W-1:0];
                    lo_d = {lo_q[DATA_W-2:0], 1'b0};
                end
            end else begin
                hi_d = mul_sum[DATA_W:1];
                lo_d = {mul_sum[0], lo_q[DATA_W-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            run_q  <= 1'b0;
            done_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
        end else begin
            run_q  <= run_d;
            done_q <= done_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            b_q    <= b_d;
        end
    end

    assign done_o = done_q;
    assign res_o  = {hi_q, lo_q};

endmodule

// File: rtl/alu_exec.sv
// ALU execution stage. Latches a decoded command on parser_done, executes it
// (single-cycle logic/add ops, multi-cycle MUL/DIV via alu_seq_muldiv) and
// presents a 2*DATA_W result with a valid/ready handshake.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   data_type, operator         decoded command fields (1 = signed)
//   src1, src2, parser_done     operands and command strobe
//   result, result_valid, err   response (err[0] div-by-zero, err[1] illegal op)
//   result_ready                consumer accepts the response
//   busy                        FSM not idle
//   cmd_drop                    one-cycle pulse when a command was lost
// Build option: define ALU_EXEC_PENDING_EN to add a one-entry pending command
// slot that absorbs a command arriving while busy.
module alu_exec
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            data_type,
    input  logic [4:0]            operator,
    input  logic [DATA_W-1:0]     src1,
    input  logic [DATA_W-1:0]     src2,
    input  logic                  parser_done,
    output logic [2*DATA_W-1:0]   result,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [1:0]            err,
    output logic                  busy,
    output logic                  cmd_drop
);

    state_e                state_q, state_d;
    logic [3:0]            dt_q, dt_d;
    logic [4:0]            op_q, op_d;
    logic [DATA_W-1:0]     a_q, a_d;
    logic [DATA_W-1:0]     b_q, b_d;
    logic [2*DATA_W-1:0]   res_q, res_d;
    logic [1:0]            err_q, err_d;
    logic                  valid_q, valid_d;
    logic                  drop_q, drop_d;
    logic                  ld_en;

    // Command being loaded into EXEC (from the inputs or the pending slot).
    logic [3:0]            c_dt;
    logic [4:0]            c_op;
    logic [DATA_W-1:0]     c_a, c_b;

`ifdef ALU_EXEC_PENDING_EN
    logic                  pend_q, pend_d;
    logic [3:0]            pdt_q, pdt_d;
    logic [4:0]            pop_q, pop_d;
    logic [DATA_W-1:0]     pa_q, pa_d, pb_q, pb_d;

    // Whenever a load happens with the slot full, the slot is what gets loaded.
    assign c_dt = pend_q ? pdt_q : data_type;
    assign c_op = pend_q ? pop_q : operator;
    assign c_a  = pend_q ? pa_q  : src1;
    assign c_b  = pend_q ? pb_q  : src2;
`else
    assign c_dt = data_type;
    assign c_op = operator;
    assign c_a  = src1;
    assign c_b  = src2;
`endif

    // Engine operates on magnitudes of the command being loaded.
    logic                  c_signed, c_is_div, md_start, md_done;
    logic [DATA_W-1:0]     mag_a, mag_b;
    logic [2*DATA_W-1:0]   md_res;

    assign c_signed = (c_dt == DT_SIGNED);
    assign c_is_div = (c_op == OP_DIV);
    assign mag_a    = (c_signed && c_a[DATA_W-1]) ? -c_a : c_a;
    assign mag_b    = (c_signed && c_b[DATA_W-1]) ? -c_b : c_b;
    assign md_start = ld_en && ((c_op == OP_MUL) || (c_is_div && (c_b != '0)));

    alu_seq_muldiv #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_muldiv (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (md_start),
        .is_div_i (c_is_div),
        .a_i      (mag_a),
        .b_i      (mag_b),
        .done_o   (md_done),
        .res_o    (md_res)
    );

    // Result computation for the latched command.
    logic                  s_q, neg_a, neg_b, iter_op;
    logic [DATA_W:0]       a_ext, b_ext, add_r, sub_r;
    logic [DATA_W-1:0]     quo, rem, quo_f, rem_f;
    logic [2*DATA_W-1:0]   prod, iter_res, simple_res;
    logic [1:0]            simple_err;

    assign s_q     = (dt_q == DT_SIGNED);
    assign neg_a   = s_q & a_q[DATA_W-1];
    assign neg_b   = s_q & b_q[DATA_W-1];
    assign iter_op = (op_q == OP_MUL) || ((op_q == OP_DIV) && (b_q != '0));

    assign a_ext   = s_q ? {a_q[DATA_W-1], a_q} : {1'b0, a_q};
    assign b_ext   = s_q ? {b_q[DATA_W-1], b_q} : {1'b0, b_q};
    assign add_r   = a_ext + b_ext;
    assign sub_r   = a_ext - b_ext;

    assign prod    = (neg_a ^ neg_b) ? -md_res : md_res;
    assign quo     = md_res[DATA_W-1:0];
    assign rem     = md_res[2*DATA_W-1:DATA_W];
    assign quo_f   = (neg_a ^ neg_b) ? -quo : quo;
    assign rem_f   = neg_a ? -rem : rem;
    assign iter_res = (op_q == OP_MUL) ? prod : {rem_f, quo_f};

    always_comb begin
        simple_res = '0;
        simple_err = '0;
        case (op_q)
            OP_ADD: simple_res = s_q ? {{(DATA_W-1){add_r[DATA_W]}}, add_r}
                                     : {{(DATA_W-1){1'b0}}, add_r};
            OP_SUB: simple_res = s_q ? {{(DATA_W-1){sub_r[DATA_W]}}, sub_r}
                                     : {{(DATA_W-1){1'b0}}, sub_r};
            OP_AND: simple_res = {{DATA_W{1'b0}}, a_q & b_q};
            OP_OR:  simple_res = {{DATA_W{1'b0}}, a_q | b_q};
            OP_XOR: simple_res = {{DATA_W{1'b0}}, a_q ^ b_q};
            OP_MUL: simple_res = '0;
            // Only reached with a zero divisor: quotient all ones, remainder = src1.
            OP_DIV: begin
                simple_res = {a_q, {DATA_W{1'b1}}};
                simple_err[ERR_DIV0] = 1'b1;
            end
            default: simple_err[ERR_ILLEGAL] = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        dt_d    = dt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = err_q;
        valid_d = valid_q;
        drop_d  = 1'b0;
        ld_en   = 1'b0;
`ifdef ALU_EXEC_PENDING_EN
        pend_d  = pend_q;
        pdt_d   = pdt_q;
        pop_d   = pop_q;
        pa_d    = pa_q;
        pb_d    = pb_q;
`endif

        unique case (state_q)
            StIdle: begin
`ifdef ALU_EXEC_PENDING_EN
                if (pend_q) begin
                    ld_en  = 1'b1;
                    pend_d = 1'b0;
                end else if (parser_done) begin
                    ld_en = 1'b1;
                end
`else
                if (parser_done) begin
                    ld_en = 1'b1;
                end
`endif
            end
            StExec: begin
                if (!iter_op || md_done) begin
                    res_d   = iter_op ? iter_res : simple_res;
                    err_d   = iter_op ? 2'b00 : simple_err;
                    valid_d = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (result_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
`ifdef ALU_EXEC_PENDING_EN
                    if (pend_q) begin
                        ld_en  = 1'b1;
                        pend_d = 1'b0;
                    end
`endif
                end
            end
            default: state_d = StIdle;
        endcase

        if (ld_en) begin
            state_d = StExec;
            dt_d    = c_dt;
            op_d    = c_op;
            a_d     = c_a;
            b_d     = c_b;
        end

`ifdef ALU_EXEC_PENDING_EN
        // A strobe not consumed directly goes to the slot if it was empty at this edge.
        if (parser_done && !((state_q == StIdle) && !pend_q)) begin
            if (!pend_q) begin
                pend_d = 1'b1;
                pdt_d  = data_type;
                pop_d  = operator;
                pa_d   = src1;
                pb_d   = src2;
            end else begin
                drop_d = 1'b1;
            end
        end
`else
        if (parser_done && (state_q != StIdle)) begin
            drop_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            dt_q    <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dt_q    <= dt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

`ifdef ALU_EXEC_PENDING_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
            pdt_q  <= '0;
            pop_q  <= '0;
            pa_q   <= '0;
            pb_q   <= '0;
        end else begin
            pend_q <= pend_d;
            pdt_q  <= pdt_d;
            pop_q  <= pop_d;
            pa_q   <= pa_d;
            pb_q   <= pb_d;
        end
    end
`endif

    assign result       = res_q;
    assign result_valid = valid_q;
    assign err          = err_q;
    assign busy         = (state_q != StIdle);
    assign cmd_drop     = drop_q;

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execution stage directly downstream of the command decoder.
- Latches the decoded fields (data_type, operator, src1, src2) on the parser_done pulse and executes the operation.
- Logic ops complete in one cycle; MUL and DIV are multi-cycle sequential.
- Presents a 2*DATA_W-bit result with a valid/ready handshake to the response/TX stage.

Parameters:
- DATA_W, 16, operand width; result width is 2*DATA_W.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_type  in  4  1 = signed; any other value = unsigned.
- operator  in  5  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6 DIV; others illegal.
- src1  in  DATA_W  operand A / dividend.
- src2  in  DATA_W  operand B / divisor.
- parser_done  in  1  one-cycle command-valid strobe.
- result  out  2*DATA_W  operation result.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.
- err  out  2  bit0 = divide-by-zero, bit1 = illegal operator; valid with result.
- busy  out  1  state != IDLE.
- cmd_drop  out  1  one-cycle pulse when a command is lost.

Behaviour:
- Reset (async): state=IDLE; result=0, result_valid=0, err=0, busy=0, cmd_drop=0; counter and operand registers cleared.
- FSM states: IDLE, EXEC, DONE.
- IDLE: parser_done=1 at edge k captures all fields. Go to EXEC, cnt=0.
- EXEC, ops 0-4 and illegal ops: edge k+1 writes result and err, enters DONE, result_valid=1.
- EXEC, MUL/DIV: edges k+1..k+DATA_W each perform one iteration (shift-add multiply; restoring divide). Edge k+DATA_W+1 applies the sign fix and writes result, then DONE.
- DONE: result, err and result_valid hold stable until result_valid && result_ready at an edge. That edge clears result_valid and returns to IDLE.
- Arithmetic widths:
  - ADD/SUB: DATA_W+1-bit result (carry/borrow included), sign-extended if signed, else zero-extended, to 2*DATA_W.
  - AND/OR/XOR: zero-extended.
  - MUL: full 2*DATA_W product.
  - DIV: result = {remainder, quotient}.
- Signed MUL/DIV: operate on magnitudes. Quotient/product sign = XOR of operand signs; remainder takes the dividend's sign.
- DIV by zero: quotient = all ones, remainder = src1, err[0]=1. No iterations; completes at edge k+1.
- Illegal operator: result=0, err[1]=1, completes at edge k+1.
- parser_done while busy (EXEC/DONE), without the optional feature: command ignored, cmd_drop pulses in the next cycle.
- parser_done in IDLE coincident with nothing pending: accepted normally.
- Reset mid-operation: the operation is aborted immediately. No result is produced after reset release.

Optional Feature:
- Macro: ALU_EXEC_PENDING_EN.
- Defined:
  - One-entry pending register captures a command arriving during EXEC/DONE.
  - On the DONE handshake edge, go directly to EXEC with the pending command (no IDLE cycle).
  - cmd_drop only when the pending entry is already full.
  - A parser_done on the handshake edge itself fills pending, if empty.
- Undefined: no pending register; behaviour as above.

Decomposition:
- Shared package alu_pkg: operator codes (OP_ADD..OP_DIV), DT_SIGNED constant, FSM state enum, err bit indices.
- One natural sub-module, alu_seq_muldiv:
  - Iterative magnitude multiply/divide engine with start/done.
  - Top handles sign fix and the simple ops.

Test Plan:
- Single-cycle op: ADD unsigned, src1=16'hFFFF, src2=16'h0001. Expect result=32'h0001_0000, result_valid 1 cycle after capture edge, err=0.
- Signed multiply: MUL signed, src1=-3 (16'hFFFD), src2=7. Expect result=32'hFFFF_FFEB after DATA_W+1 cycles; busy high throughout.
- Signed divide: DIV signed, src1=-7, src2=2. Expect quotient=16'hFFFD (-3), remainder=16'hFFFF (-1), i.e. result=32'hFFFF_FFFD.
- Divide-by-zero and illegal op:
  - DIV src1=16'h1234, src2=0: expect result=32'h1234_FFFF, err=2'b01.
  - operator=5'd9: expect result=0, err=2'b10.
- Backpressure and overlap: hold result_ready=0 for 10 cycles, then pulse two parser_done during DONE.
  - Result stable throughout.
  - Without macro: two cmd_drop pulses.
  - With macro: first command executes right after the handshake; second drops.
- Reset mid-MUL: assert rst at iteration 8. Expect all outputs 0 immediately, state IDLE, and no result_valid after release.
